// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - opcode constants, decode classes and decoded control struct for dec_stage
package dec_pkg;

    localparam int OP_R_MAX  = 5;
    localparam int OP_CMP    = 6;
    localparam int OP_RSV_LO = 7;
    localparam int OP_RSV_HI = 10;
    localparam int OP_R_ALT  = 11;
    localparam int OP_LD     = 12;
    localparam int OP_ST     = 13;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_CMP,
        CLS_LD,
        CLS_ST,
        CLS_J,
        CLS_RSV
    } dec_class_e;

    typedef struct packed {
        dec_class_e cls;
        logic       we_rf;
        logic       we_dmem;
        logic       illegal;
    } dec_fields_t;

    // Base classification; the reserved range folds into J here and is
    // overridden by the decoder when the illegal-opcode trap is built in.
    function automatic dec_class_e op_class(input logic [31:0] op);
        if (op <= 32'(OP_R_MAX) || op == 32'(OP_R_ALT)) begin
            return CLS_R;
        end else if (op == 32'(OP_CMP)) begin
            return CLS_CMP;
        end else if (op >= 32'(OP_RSV_LO) && op <= 32'(OP_RSV_HI)) begin
            return CLS_J;
        end else if (op == 32'(OP_LD)) begin
            return CLS_LD;
        end else if (op == 32'(OP_ST)) begin
            return CLS_ST;
        end else begin
            return CLS_J;
        end
    endfunction

endpackage

// File: rtl/dec_fields.sv
// rtl/dec_fields.sv - combinational instruction splitter: fields, control and read-use mask
// Optional feature macro: DEC_ILLEGAL_EN (ops 7..10 decode as reserved/illegal).
module dec_fields
    import dec_pkg::*;
#(
    parameter int OP_W   = 5,
    parameter int REG_W  = 5,
    parameter int INST_W = 20
) (
    input  logic [INST_W-1:0]      i_inst,
    output dec_fields_t            o_ctl,
    output logic [2:0]             o_use,
    output logic [OP_W-1:0]        o_op,
    output logic [REG_W-1:0]       o_rd,
    output logic [REG_W-1:0]       o_rt,
    output logic [REG_W-1:0]       o_rs,
    output logic [INST_W-OP_W-1:0] o_bamt
);

    logic [31:0] w_opx;
    logic        w_rsv;
    dec_class_e  w_cls;
    logic [REG_W-1:0] w_rd_raw;
    logic [REG_W-1:0] w_rt_raw;
    logic [REG_W-1:0] w_rs_raw;

    assign o_op     = i_inst[INST_W-1 -: OP_W];
    assign w_opx    = 32'(o_op);
    assign w_rd_raw = i_inst[3*REG_W-1 -: REG_W];
    assign w_rt_raw = i_inst[2*REG_W-1 -: REG_W];
    assign w_rs_raw = i_inst[REG_W-1:0];

`ifdef DEC_ILLEGAL_EN
    assign w_rsv = (w_opx >= 32'(OP_RSV_LO)) && (w_opx <= 32'(OP_RSV_HI));
`else
    assign w_rsv = 1'b0;
`endif

    assign w_cls = w_rsv ? CLS_RSV : op_class(w_opx);

    // o_use bit order: {rd, rt, rs}
    always_comb begin
        o_ctl     = '0;
        o_ctl.cls = w_cls;
        o_use     = 3'b000;
        o_rd      = '0;
        o_rt      = '0;
        o_rs      = '0;
        o_bamt    = '0;
        case (w_cls)
            CLS_R, CLS_LD: begin
                o_ctl.we_rf = 1'b1;
                o_use       = 3'b011;
                o_rd        = w_rd_raw;
                o_rt        = w_rt_raw;
                o_rs        = w_rs_raw;
            end
            CLS_CMP: begin
                o_use = 3'b011;
                o_rd  = w_rd_raw;
                o_rt  = w_rt_raw;
                o_rs  = w_rs_raw;
            end
            CLS_ST: begin
                o_ctl.we_dmem = 1'b1;
                o_use         = 3'b110;
                o_rd          = w_rd_raw;
                o_rt          = w_rt_raw;
            end
            CLS_J: begin
                o_bamt = i_inst[INST_W-OP_W-1:0];
            end
            CLS_RSV: begin
                o_ctl.illegal = 1'b1;
            end
            default: begin
                o_ctl.illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dec_stage.sv
// rtl/dec_stage.sv - registered decode stage with valid/ready, load-use interlock, flush, stall counter
// Optional feature macro: DEC_ILLEGAL_EN (handled in dec_fields).
module dec_stage
    import dec_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int REG_W   = 5,
    parameter int INST_W  = 20,
    parameter int STALL_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INST_W-1:0]      inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OP_W-1:0]        op,
    output logic [REG_W-1:0]       rd,
    output logic [REG_W-1:0]       rt,
    output logic [REG_W-1:0]       rs,
    output logic [INST_W-OP_W-1:0] bamt,
    output logic                   we_rf,
    output logic                   we_dmem,
    output logic                   illegal,
    output logic [STALL_W-1:0]     stall_count
);

    dec_fields_t             w_ctl;
    logic [2:0]              w_use;
    logic [OP_W-1:0]         w_op;
    logic [REG_W-1:0]        w_rd;
    logic [REG_W-1:0]        w_rt;
    logic [REG_W-1:0]        w_rs;
    logic [INST_W-OP_W-1:0]  w_bamt;
    logic                    w_hazard;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_bubble;

    logic                    r_out_valid;
    dec_class_e              r_cls;
    logic [OP_W-1:0]         r_op;
    logic [REG_W-1:0]        r_rd;
    logic [REG_W-1:0]        r_rt;
    logic [REG_W-1:0]        r_rs;
    logic [INST_W-OP_W-1:0]  r_bamt;
    logic                    r_we_rf;
    logic                    r_we_dmem;
    logic                    r_illegal;
    logic [STALL_W-1:0]      r_stall;

    dec_fields #(
        .OP_W   (OP_W),
        .REG_W  (REG_W),
        .INST_W (INST_W)
    ) u_fields (
        .i_inst (inst),
        .o_ctl  (w_ctl),
        .o_use  (w_use),
        .o_op   (w_op),
        .o_rd   (w_rd),
        .o_rt   (w_rt),
        .o_rs   (w_rs),
        .o_bamt (w_bamt)
    );

    // Held load's destination against whatever the incoming word reads;
    // evaluated regardless of in_valid so in_ready stays low across the stall.
    assign w_hazard = r_out_valid && (r_cls == CLS_LD) &&
                      ((w_use[2] && (r_rd == w_rd)) ||
                       (w_use[1] && (r_rd == w_rt)) ||
                       (w_use[0] && (r_rd == w_rs)));

    assign w_in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
    assign w_accept   = in_valid && w_in_ready;
    assign w_bubble   = in_valid && w_hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_cls       <= CLS_R;
            r_op        <= '0;
            r_rd        <= '0;
            r_rt        <= '0;
            r_rs        <= '0;
            r_bamt      <= '0;
            r_we_rf     <= 1'b0;
            r_we_dmem   <= 1'b0;
            r_illegal   <= 1'b0;
            r_stall     <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_cls       <= w_ctl.cls;
            r_op        <= w_op;
            r_rd        <= w_rd;
            r_rt        <= w_rt;
            r_rs        <= w_rs;
            r_bamt      <= w_bamt;
            r_we_rf     <= w_ctl.we_rf;
            r_we_dmem   <= w_ctl.we_dmem;
            r_illegal   <= w_ctl.illegal;
        end else if (out_ready && r_out_valid) begin
            r_out_valid <= 1'b0;
            if (w_bubble && (r_stall != {STALL_W{1'b1}})) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign op          = r_op;
    assign rd          = r_rd;
    assign rt          = r_rt;
    assign rs          = r_rs;
    assign bamt        = r_bamt;
    assign we_rf       = r_we_rf;
    assign we_dmem     = r_we_dmem;
    assign illegal     = r_illegal;
    assign stall_count = r_stall;

endmodule

// File: tb/tb_dec_stage.sv
// tb/tb_dec_stage.sv - directed self-checking bench for dec_stage (STALL_W=2 to reach saturation)
module tb_dec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] inst;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [4:0]  rs;
    logic [14:0] bamt;
    logic        we_rf;
    logic        we_dmem;
    logic        illegal;
    logic [1:0]  stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dec_stage #(
        .OP_W    (5),
        .REG_W   (5),
        .INST_W  (20),
        .STALL_W (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inst        (inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .op          (op),
        .rd          (rd),
        .rt          (rt),
        .rs          (rs),
        .bamt        (bamt),
        .we_rf       (we_rf),
        .we_dmem     (we_dmem),
        .illegal     (illegal),
        .stall_count (stall_count)
    );

    function automatic logic [19:0] mk(input logic [4:0] o, input logic [4:0] d,
                                       input logic [4:0] t, input logic [4:0] s);
        return {o, d, t, s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; inst = mk(5'd12, 5'd3, 5'd3, 5'd3);
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
        n_cmp++; if (op !== 5'd0 || rd !== 5'd0 || rt !== 5'd0 || rs !== 5'd0) begin n_bad++; $display("FAIL reset_fields got op=%0h rd=%0h rt=%0h rs=%0h want 0", op, rd, rt, rs); end
        n_cmp++; if (bamt !== 15'd0) begin n_bad++; $display("FAIL reset_bamt got %0h want 0", bamt); end
        n_cmp++; if ({we_rf, we_dmem, illegal} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %0b want 000", {we_rf, we_dmem, illegal}); end
        n_cmp++; if (stall_count !== 2'd0) begin n_bad++; $display("FAIL reset_stall got %0d want 0", stall_count); end
        reset = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_r_stream();
        logic [19:0] w [4];
        w[0] = mk(5'd0, 5'd1, 5'd2, 5'd3);
        w[1] = mk(5'd1, 5'd4, 5'd5, 5'd6);
        w[2] = mk(5'd5, 5'd7, 5'd8, 5'd9);
        w[3] = mk(5'd11, 5'd10, 5'd11, 5'd12);
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst = w[i];
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstream_in_ready[%0d] got %0b want 1", i, in_ready); end
            step();
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstream_valid[%0d] got %0b want 1", i, out_valid); end
            n_cmp++; if (op !== w[i][19:15] || rd !== w[i][14:10] || rt !== w[i][9:5] || rs !== w[i][4:0]) begin n_bad++; $display("FAIL rstream_fields[%0d] got %0h/%0h/%0h/%0h want %0h", i, op, rd, rt, rs, w[i]); end
            n_cmp++; if (we_rf !== 1'b1 || we_dmem !== 1'b0 || bamt !== 15'd0) begin n_bad++; $display("FAIL rstream_ctl[%0d] got we_rf=%0b we_dmem=%0b bamt=%0h want 1/0/0", i, we_rf, we_dmem, bamt); end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstream_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_load_use();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; inst = mk(5'd12, 5'd3, 5'd1, 5'd2);
        step();
        n_cmp++; if (out_valid !== 1'b1 || op !== 5'd12 || rd !== 5'd3) begin n_bad++; $display("FAIL lu_ld got v=%0b op=%0d rd=%0d want 1/12/3", out_valid, op, rd); end
        inst = mk(5'd0, 5'd5, 5'd6, 5'd3);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL lu_in_ready_hazard got %0b want 0", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got %0b want 0", out_valid); end
        n_cmp++; if (stall_count !== 2'd1) begin n_bad++; $display("FAIL lu_stall got %0d want 1", stall_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lu_in_ready_after got %0b want 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || op !== 5'd0 || rd !== 5'd5 || rs !== 5'd3) begin n_bad++; $display("FAIL lu_r got v=%0b op=%0d rd=%0d rs=%0d want 1/0/5/3", out_valid, op, rd, rs); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || stall_count !== 2'd1) begin n_bad++; $display("FAIL lu_end got v=%0b stall=%0d want 0/1", out_valid, stall_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; inst = mk(5'd2, 5'd3, 5'd4, 5'd5);
        step();
        n_cmp++; if (out_valid !== 1'b1 || rd !== 5'd3) begin n_bad++; $display("FAIL bp_first got v=%0b rd=%0d want 1/3", out_valid, rd); end
        out_ready = 1'b0; inst = mk(5'd3, 5'd6, 5'd7, 5'd8);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); end
            step();
            n_cmp++; if (out_valid !== 1'b1 || op !== 5'd2 || rd !== 5'd3 || rt !== 5'd4 || rs !== 5'd5) begin n_bad++; $display("FAIL bp_hold[%0d] got v=%0b op=%0d rd=%0d rt=%0d rs=%0d want 1/2/3/4/5", i, out_valid, op, rd, rt, rs); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got %0b want 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || op !== 5'd3 || rd !== 5'd6) begin n_bad++; $display("FAIL bp_second got v=%0b op=%0d rd=%0d want 1/3/6", out_valid, op, rd); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup got %0b want 0", out_valid); end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; inst = mk(5'd12, 5'd4, 5'd0, 5'd0);
        step();
        inst = mk(5'd0, 5'd1, 5'd2, 5'd4); flush = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fl_in_ready got %0b want 0", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid got %0b want 0", out_valid); end
        n_cmp++; if (stall_count !== 2'd0) begin n_bad++; $display("FAIL fl_stall got %0d want 0", stall_count); end
        flush = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b1 || op !== 5'd0 || rs !== 5'd4) begin n_bad++; $display("FAIL fl_resume got v=%0b op=%0d rs=%0d want 1/0/4", out_valid, op, rs); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_store_jump();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; inst = mk(5'd12, 5'd7, 5'd0, 5'd0);
        step();
        inst = mk(5'd13, 5'd7, 5'd8, 5'd9);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL st_rd_hazard got %0b want 0", in_ready); end
        step();
        step();
        n_cmp++; if (out_valid !== 1'b1 || we_dmem !== 1'b1 || we_rf !== 1'b0) begin n_bad++; $display("FAIL st_ctl got v=%0b we_dmem=%0b we_rf=%0b want 1/1/0", out_valid, we_dmem, we_rf); end
        n_cmp++; if (rd !== 5'd7 || rt !== 5'd8 || rs !== 5'd0 || bamt !== 15'd0) begin n_bad++; $display("FAIL st_fields got rd=%0d rt=%0d rs=%0d bamt=%0h want 7/8/0/0", rd, rt, rs, bamt); end
        inst = {5'd14, 15'h5A5A};
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL j_in_ready got %0b want 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || op !== 5'd14 || bamt !== 15'h5A5A) begin n_bad++; $display("FAIL j_bamt got v=%0b op=%0d bamt=%0h want 1/14/5a5a", out_valid, op, bamt); end
        n_cmp++; if (rd !== 5'd0 || rt !== 5'd0 || rs !== 5'd0 || we_rf !== 1'b0 || we_dmem !== 1'b0) begin n_bad++; $display("FAIL j_zero got rd=%0d rt=%0d rs=%0d we=%0b%0b want 0", rd, rt, rs, we_rf, we_dmem); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reserved_and_saturation();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; inst = {5'd8, 15'h1234};
        step();
        n_cmp++; if (out_valid !== 1'b1 || op !== 5'd8 || rd !== 5'd0) begin n_bad++; $display("FAIL rsv_pass got v=%0b op=%0d rd=%0d want 1/8/0", out_valid, op, rd); end
`ifdef DEC_ILLEGAL_EN
        n_cmp++; if (illegal !== 1'b1 || bamt !== 15'd0 || we_rf !== 1'b0) begin n_bad++; $display("FAIL rsv_decode got illegal=%0b bamt=%0h we_rf=%0b want 1/0/0", illegal, bamt, we_rf); end
`else
        n_cmp++; if (illegal !== 1'b0 || bamt !== 15'h1234 || we_rf !== 1'b0) begin n_bad++; $display("FAIL rsv_decode got illegal=%0b bamt=%0h we_rf=%0b want 0/1234/0", illegal, bamt, we_rf); end
`endif
        for (int i = 0; i < 5; i++) begin
            inst = mk(5'd12, 5'd2, 5'd0, 5'd0);
            step();
            inst = mk(5'd0, 5'd1, 5'd0, 5'd2);
            step();
            if (i == 1) begin
                n_cmp++; if (stall_count !== 2'd2) begin n_bad++; $display("FAIL sat_mid got %0d want 2", stall_count); end
            end
        end
        n_cmp++; if (stall_count !== 2'd3) begin n_bad++; $display("FAIL sat_final got %0d want 3", stall_count); end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_r_stream();
        test_load_use();
        test_backpressure();
        test_flush_hazard();
        test_store_jump();
        test_reserved_and_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
